// File: rtl/mux_scan_capture.sv
// ============================================================================
// Module   : mux_scan_capture
// Brief    : Scans an external 4:1 mux, captures one bit per channel into a
//            4-bit word, hands it downstream over valid/ready.
//            Optional MUX_SCAN_CAPTURE_PARITY_EN adds registered data_par.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan_capture #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] mux_s,
  input  logic       mux_out,
  output logic       busy,
  output logic [3:0] data,
  output logic       data_valid,
  input  logic       data_ready
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
  ,
  output logic       data_par
`endif
);

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [1:0] r_mux_s,   w_mux_s_nxt;
  logic [3:0] r_cnt,     w_cnt_nxt;
  logic [3:0] r_partial, w_partial_nxt;
  logic [3:0] r_data,    w_data_nxt;
  logic       r_valid,   w_valid_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       w_slot_free;

  // The output slot counts as free if it is empty or is being drained this edge.
  assign w_slot_free = ~r_valid | data_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_mux_s_nxt   = r_mux_s;
    w_cnt_nxt     = r_cnt;
    w_partial_nxt = r_partial;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid & ~data_ready;
    w_busy_nxt    = r_busy;
    case (r_state)
      IDLE: begin
        if (start && w_slot_free) begin
          w_state_nxt   = SETTLE;
          w_mux_s_nxt   = 2'b00;
          w_cnt_nxt     = 4'd0;
          w_busy_nxt    = 1'b1;
          w_partial_nxt = 4'b0000;
        end
      end
      SETTLE: begin
        if (r_cnt == C_SETTLE_LAST) begin
          w_state_nxt = SAMPLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        w_partial_nxt[r_mux_s] = mux_out;
        if (r_mux_s != 2'b11) begin
          w_mux_s_nxt = r_mux_s + 2'b01;
          w_state_nxt = SETTLE;
        end else begin
          w_data_nxt  = {mux_out, r_partial[2:0]};
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_mux_s_nxt = 2'b00;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_mux_s_nxt = 2'b00;
        w_cnt_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mux_s   <= 2'b00;
      r_cnt     <= 4'd0;
      r_partial <= 4'b0000;
      r_data    <= 4'b0000;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mux_s   <= w_mux_s_nxt;
      r_cnt     <= w_cnt_nxt;
      r_partial <= w_partial_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign mux_s      = r_mux_s;
  assign busy       = r_busy;
  assign data       = r_data;
  assign data_valid = r_valid;

`ifdef MUX_SCAN_CAPTURE_PARITY_EN
  logic r_par;

  // Parity follows the next data value so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else begin
      r_par <= ^w_data_nxt;
    end
  end

  assign data_par = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: two instances (SETTLE_CYCLES 2 and 1),
// behavioural 4:1 muxes, and per-instance queues of expected words.
`default_nettype none

module tb_mux_scan_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  // Instance 0: SETTLE_CYCLES = 2
  logic       start0, ready0, mux_out0, busy0, dv0;
  logic [1:0] mux_s0;
  logic [3:0] data0;
  logic [3:0] ins0;  // bit0 = a ... bit3 = d
  // Instance 1: SETTLE_CYCLES = 1
  logic       start1, ready1, mux_out1, busy1, dv1;
  logic [1:0] mux_s1;
  logic [3:0] data1;
  logic [3:0] ins1;
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
  logic       par0, par1;
`endif

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  assign mux_out0 = ins0[mux_s0];
  assign mux_out1 = ins1[mux_s1];

  always #5 clk = ~clk;

  mux_scan_capture #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mux_s(mux_s0),
    .mux_out(mux_out0), .busy(busy0), .data(data0), .data_valid(dv0),
    .data_ready(ready0)
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    , .data_par(par0)
`endif
  );

  mux_scan_capture #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_s(mux_s1),
    .mux_out(mux_out1), .busy(busy1), .data(data1), .data_valid(dv1),
    .data_ready(ready1)
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    , .data_par(par1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop0(input string tag);
    logic [3:0] w;
    if (q0.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed word %0h with no expected word queued", tag, data0);
    end else begin
      w = q0.pop_front();
      chk(tag, data0, w);
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
      chk({tag, "_par"}, par0, ^w);
`endif
    end
  endtask

  task automatic pop1(input string tag);
    logic [3:0] w;
    if (q1.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed word %0h with no expected word queued", tag, data1);
    end else begin
      w = q1.pop_front();
      chk(tag, data1, w);
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
      chk({tag, "_par"}, par1, ^w);
`endif
    end
  endtask

  task automatic wait_valid0(input int budget);
    int n = 0;
    while (!dv0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid0", dv0, 1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; ready0 = 1'b0; ins0 = 4'b0000;
    start1 = 1'b0; ready1 = 1'b0; ins1 = 4'b0000;
    tick();
    tick();
    chk("rst_mux_s", mux_s0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_data", data0, 0);
    chk("rst_valid", dv0, 0);
`ifdef MUX_SCAN_CAPTURE_PARITY_EN
    chk("rst_par", par0, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic scan: a=1 b=0 c=1 d=1
    ins0   = 4'b1101;
    start0 = 1'b1;
    q0.push_back(ins0);
    tick();
    start0 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("basic_mux_s", mux_s0, j / 3);
      chk("basic_busy", busy0, 1);
      chk("basic_valid_low", dv0, 0);
      tick();
    end
    chk("basic_busy_end", busy0, 0);
    chk("basic_valid", dv0, 1);
    chk("basic_mux_s_end", mux_s0, 0);
    pop0("basic_data");

    // Backpressure: word held, starts ignored
    ins0 = 4'b0000;
    for (int j = 0; j < 20; j++) begin
      start0 = (j == 5 || j == 12);
      tick();
      chk("bp_valid", dv0, 1);
      chk("bp_busy", busy0, 0);
      chk("bp_data", data0, 4'b1101);
    end
    start0 = 1'b0;
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    chk("bp_drain_valid", dv0, 0);
    chk("bp_drain_data", data0, 4'b1101);
    chk("bp_drain_busy", busy0, 0);

    // Back-to-back: produce a word, then drain and restart on the same edge
    ins0   = 4'b1101;
    start0 = 1'b1;
    q0.push_back(ins0);
    tick();
    start0 = 1'b0;
    wait_valid0(40);
    pop0("b2b_first");
    ins0   = 4'b0110;
    start0 = 1'b1;
    ready0 = 1'b1;
    q0.push_back(ins0);
    tick();
    start0 = 1'b0;
    ready0 = 1'b0;
    chk("b2b_valid_clr", dv0, 0);
    chk("b2b_busy", busy0, 1);
    for (int j = 0; j < 11; j++) tick();
    chk("b2b_valid_early", dv0, 0);
    tick();
    chk("b2b_valid", dv0, 1);
    chk("b2b_busy_end", busy0, 0);
    pop0("b2b_data");
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;

    // Start while busy: extra pulses at cycles 3 and 7
    ins0   = 4'b1011;
    start0 = 1'b1;
    q0.push_back(ins0);
    tick();
    for (int j = 0; j < 12; j++) begin
      start0 = (j == 3 || j == 7);
      chk("sb_busy", busy0, 1);
      chk("sb_valid_low", dv0, 0);
      tick();
    end
    start0 = 1'b0;
    chk("sb_valid", dv0, 1);
    pop0("sb_data");
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      chk("sb_no_extra_busy", busy0, 0);
      chk("sb_no_extra_valid", dv0, 0);
      tick();
    end

    // Reset mid-scan while mux_s = 10
    ins0   = 4'b1111;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("mr_pre_mux_s", mux_s0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_mux_s", mux_s0, 0);
    chk("mr_busy", busy0, 0);
    chk("mr_valid", dv0, 0);
    chk("mr_data", data0, 0);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("mr_no_word", dv0, 0);
      chk("mr_idle", busy0, 0);
    end

    // Settle parameter 1 on the second instance
    ins1   = 4'b1111;
    start1 = 1'b1;
    q1.push_back(ins1);
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("s1_mux_s", mux_s1, j / 2);
      chk("s1_busy", busy1, 1);
      chk("s1_valid_low", dv1, 0);
      tick();
    end
    chk("s1_valid", dv1, 1);
    chk("s1_busy_end", busy1, 0);
    pop1("s1_data");

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
